exe_mem_reg: RTL and testbench

//  Pipeline boundary directly downstream of the execute-stage ALU.

---
 rtl/exe_mem_reg_pkg.sv | 26 ++
 rtl/exe_mem_reg_status_reg_unit.sv | 24 ++
 rtl/exe_mem_reg.sv | 153 +++++++++++++++
 tb/tb_exe_mem_reg.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_reg_pkg.sv
// Shared widths, status flag bit positions and EXE/MEM buffer state encodings
// for the execute-to-memory pipeline boundary.
package exe_mem_reg_pkg;

  localparam int REGISTER_FILE_LEN = 32;
  localparam int STATUS_REG_LEN    = 4;
  localparam int REG_ADDR_LEN      = 4;

  // Status register layout {Z,C,N,V}
  localparam int STATUS_Z = 3;
  localparam int STATUS_C = 2;
  localparam int STATUS_N = 1;
  localparam int STATUS_V = 0;

  typedef enum logic [1:0] {
    EXE_MEM_EMPTY = 2'd0,
    EXE_MEM_ONE   = 2'd1,
    EXE_MEM_FULL  = 2'd2
  } buf_state_e;

  // Carry bit as seen by the ALU carry_in.
  function automatic logic carry_of(input logic [STATUS_REG_LEN-1:0] status);
    return status[STATUS_C];
  endfunction

endpackage

// File: rtl/exe_mem_reg_status_reg_unit.sv
// Architectural status register {Z,C,N,V}: loads on enable, clears on reset.
module status_reg_unit
  import exe_mem_reg_pkg::*;
#(
  parameter int W = STATUS_REG_LEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state is always written with <= so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with valid/ready handshake and status register.
// Define EXE_MEM_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module exe_mem_reg
  import exe_mem_reg_pkg::*;
#(
  parameter int DATA_W     = REGISTER_FILE_LEN,
  parameter int REG_ADDR_W = REG_ADDR_LEN,
  parameter int STATUS_W   = STATUS_REG_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic [DATA_W-1:0]     val_rm,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  wb_en,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic                  s_bit,
  input  logic [STATUS_W-1:0]   status_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_res,
  output logic [DATA_W-1:0]     out_val_rm,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_wb_en,
  output logic                  out_mem_r_en,
  output logic                  out_mem_w_en,
  output logic [STATUS_W-1:0]   status_q
);

  localparam int PL_W = 2 * DATA_W + REG_ADDR_W + 3;

  buf_state_e      state_q, state_d;
  logic [PL_W-1:0] in_payload;
  logic [PL_W-1:0] out_q;
  logic [PL_W-1:0] out_src;
  logic            load_out;
  logic            accept;
  logic            push;
  logic            rel;
  logic            wb_q, mem_r_q, mem_w_q;

  assign in_payload = {alu_res, val_rm, dest, wb_en, mem_r_en, mem_w_en};
  assign out_valid  = (state_q != EXE_MEM_EMPTY);
  assign accept     = in_valid & in_ready;
  // A flushed beat is consumed but never becomes an entry.
  assign push       = accept & ~flush;
  assign rel        = out_valid & out_ready;

`ifdef EXE_MEM_SKID_EN
  logic [PL_W-1:0] skid_q;
  logic            load_skid;
  logic            in_ready_q;

  // NOTE: every signal assigned in always_comb gets a default first,
  // otherwise untaken branches infer latches.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    out_src   = in_payload;
    unique case (state_q)
      EXE_MEM_EMPTY: begin
        if (push) begin
          state_d  = EXE_MEM_ONE;
          load_out = 1'b1;
        end
      end
      EXE_MEM_ONE: begin
        if (push && !rel) begin
          state_d   = EXE_MEM_FULL;
          load_skid = 1'b1;
        end else if (push && rel) begin
          load_out = 1'b1;
        end else if (rel) begin
          state_d = EXE_MEM_EMPTY;
        end
      end
      EXE_MEM_FULL: begin
        // in_ready is low here, so only the skid entry can advance.
        if (rel) begin
          state_d  = EXE_MEM_ONE;
          load_out = 1'b1;
          out_src  = skid_q;
        end
      end
      default: state_d = EXE_MEM_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != EXE_MEM_FULL);
      if (load_skid) begin
        skid_q <= in_payload;
      end
    end
  end

  assign in_ready = in_ready_q;
`else
  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    out_src  = in_payload;
    if (push) begin
      state_d  = EXE_MEM_ONE;
      load_out = 1'b1;
    end else if (rel) begin
      state_d = EXE_MEM_EMPTY;
    end
  end

  // Combinational from out_ready so a draining entry can be replaced in place.
  assign in_ready = ~out_valid | out_ready;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EXE_MEM_EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_out) begin
        out_q <= out_src;
      end
    end
  end

  assign {out_alu_res, out_val_rm, out_dest, wb_q, mem_r_q, mem_w_q} = out_q;

  // Controls are masked so the memory stage never acts on a stale entry.
  assign out_wb_en    = wb_q    & out_valid;
  assign out_mem_r_en = mem_r_q & out_valid;
  assign out_mem_w_en = mem_w_q & out_valid;

  status_reg_unit #(
    .W (STATUS_W)
  ) u_status (
    .clk   (clk),
    .rst_n (rst),
    .en    (push & s_bit),
    .d     (status_in),
    .q     (status_q)
  );

endmodule

// File: tb/tb_exe_mem_reg.sv
// Self-checking bench for exe_mem_reg: queue-based reference model checked every
// cycle, plus directed streaming, backpressure, flag, flush, store and reset cases.
module tb_exe_mem_reg;

`ifdef EXE_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush;
  logic [31:0] alu_res, val_rm;
  logic [3:0]  dest;
  logic        wb_en, mem_r_en, mem_w_en, s_bit;
  logic [3:0]  status_in;
  logic        out_valid, out_ready;
  logic [31:0] out_alu_res, out_val_rm;
  logic [3:0]  out_dest;
  logic        out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [3:0]  status_q;

  exe_mem_reg dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .alu_res      (alu_res),
    .val_rm       (val_rm),
    .dest         (dest),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .s_bit        (s_bit),
    .status_in    (status_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_res  (out_alu_res),
    .out_val_rm   (out_val_rm),
    .out_dest     (out_dest),
    .out_wb_en    (out_wb_en),
    .out_mem_r_en (out_mem_r_en),
    .out_mem_w_en (out_mem_w_en),
    .status_q     (status_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of live entries plus the flag register.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] v;
    logic [3:0]  d;
    logic        wb;
    logic        r;
    logic        w;
  } beat_t;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  d;
  } rel_t;

  beat_t      q[$];
  logic [3:0] m_status = 4'b0000;
  rel_t       released[$];

  function automatic logic exp_ready();
`ifdef EXE_MEM_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_status = 4'b0000;
    end else begin
      logic acc;
      acc = in_valid && exp_ready();
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc && !flush) begin
        q.push_back('{a: alu_res, v: val_rm, d: dest, wb: wb_en, r: mem_r_en, w: mem_w_en});
        if (s_bit) m_status = status_in;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready", in_ready, exp_ready());
      check("out_valid", out_valid, q.size() > 0);
      check("status_q", status_q, m_status);
      if (q.size() > 0) begin
        check("out_alu_res", out_alu_res, q[0].a);
        check("out_val_rm", out_val_rm, q[0].v);
        check("out_dest", out_dest, q[0].d);
        check("out_ctrl", {out_wb_en, out_mem_r_en, out_mem_w_en}, {q[0].wb, q[0].r, q[0].w});
      end else begin
        check("out_ctrl_idle", {out_wb_en, out_mem_r_en, out_mem_w_en}, 3'b000);
      end
      if (out_valid && out_ready) released.push_back('{a: out_alu_res, d: out_dest});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    alu_res   = '0;
    val_rm    = '0;
    dest      = '0;
    wb_en     = 1'b0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    s_bit     = 1'b0;
    status_in = '0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] v, input logic [3:0] d,
                      input logic wb, input logic w, input logic s, input logic [3:0] st,
                      input logic fl);
    in_valid  = 1'b1;
    alu_res   = a;
    val_rm    = v;
    dest      = d;
    wb_en     = wb;
    mem_r_en  = 1'b0;
    mem_w_en  = w;
    s_bit     = s;
    status_in = st;
    flush     = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cnt;
    int guard;

    rst = 1'b0;
    out_ready = 1'b0;
    idle();
    #2;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_status", status_q, 4'b0000);
    check("reset_mem_w", out_mem_w_en, 1'b0);
    check("reset_alu", out_alu_res, 32'h0);
    check("reset_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b1;

    // Streaming: 8 back-to-back beats, 1-cycle latency, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      step();
      if (i < 8) beat(32'(i + 1), 32'h0, 4'(i), 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      else idle();
      @(negedge clk);
      if (i >= 1) begin
        check("stream_valid", out_valid, 1'b1);
        check("stream_alu", out_alu_res, 64'(i));
      end
    end
    repeat (3) step();

    // Backpressure
    released.delete();
    out_ready = 1'b0;
    sent = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      beat(32'(100 + sent), 32'h0, 4'(sent), 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    check("bp_accepted", 64'(sent), 64'(CAP));
    check("bp_in_ready_low", in_ready, 1'b0);
    guard = 0;
    while (sent < 5 && guard < 20) begin
      step();
      out_ready = 1'b1;
      beat(32'(100 + sent), 32'h0, 4'(sent), 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      guard++;
    end
    check("bp_all_sent", 64'(sent), 64'd5);
    step();
    idle();
    repeat (4) step();
    check("bp_release_count", 64'(released.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < released.size()) check("bp_order", released[k].a, 32'(100 + k));
    end

    // Flags: CMP sets, following ADD without s_bit leaves them
    step();
    out_ready = 1'b1;
    beat(32'd7, 32'h0, 4'd1, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
    step();
    beat(32'd8, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0);
    @(negedge clk);
    check("flag_set", status_q, 4'b1100);
    check("flag_carry", status_q[2], 1'b1);
    step();
    idle();
    @(negedge clk);
    check("flag_hold", status_q, 4'b1100);

    // Flush: consumed, discarded, no flag update
    step();
    released.delete();
    beat(32'h55, 32'h0, 4'd5, 1'b1, 1'b0, 1'b1, 4'b0101, 1'b1);
    step();
    idle();
    repeat (3) step();
    check("flush_status", status_q, 4'b1100);
    check("flush_no_beat", 64'(released.size()), 64'd0);
    check("flush_out_valid", out_valid, 1'b0);

    // Store held under backpressure, then exactly one write-enable cycle
    step();
    out_ready = 1'b0;
    beat(32'h0000_0040, 32'hDEAD_BEEF, 4'd3, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("store_valid", out_valid, 1'b1);
      check("store_w_en", out_mem_w_en, 1'b1);
      check("store_addr", out_alu_res, 32'h0000_0040);
      check("store_data", out_val_rm, 32'hDEAD_BEEF);
      step();
    end
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_mem_w_en && out_ready) cnt++;
      step();
    end
    check("store_one_write", 64'(cnt), 64'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step();
      in_valid  = ($urandom_range(99, 0) < 70);
      out_ready = ($urandom_range(99, 0) < 60);
      flush     = ($urandom_range(99, 0) < 10);
      alu_res   = $urandom;
      val_rm    = $urandom;
      dest      = 4'($urandom_range(15, 0));
      wb_en     = 1'($urandom_range(1, 0));
      mem_r_en  = 1'($urandom_range(1, 0));
      mem_w_en  = 1'($urandom_range(1, 0));
      s_bit     = 1'($urandom_range(1, 0));
      status_in = 4'($urandom_range(15, 0));
    end
    step();
    idle();
    out_ready = 1'b1;
    repeat (4) step();

    // Reset in the middle of a stall
    out_ready = 1'b0;
    beat(32'h11, 32'h0, 4'd6, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0);
    step();
    beat(32'h12, 32'h0, 4'd7, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0);
    step();
    idle();
    check("pre_reset_status", status_q, 4'b1010);
    check("pre_reset_valid", out_valid, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check("midreset_valid", out_valid, 1'b0);
    check("midreset_status", status_q, 4'b0000);
    check("midreset_mem_w", out_mem_w_en, 1'b0);
    step();
    rst = 1'b1;
    released.delete();
    out_ready = 1'b1;
    repeat (4) step();
    check("no_replay", 64'(released.size()), 64'd0);
    check("post_reset_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
